alu_nbit_seq: RTL
=================

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid  input  1  operation request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port op  input  4  operation select, encoding per REQ-011.
REQ-007 The block SHALL have ports a and b  input  WIDTH  operands; cin  input  1  external carry-in; use_cf  input  1  take carry-in from stored carry flag instead of cin.
REQ-008 The block SHALL have ports out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-009 The block SHALL have ports y  output  WIDTH  result; z, n, c, v  output  1 each  zero/negative/carry/signed-overflow flags; err  output  1  illegal op.

Function
REQ-010 Accept SHALL occur when in_valid and in_ready are both 1 on a clk edge; in_ready SHALL equal (not out_valid) or out_ready.
REQ-011 Op encoding SHALL be: 0000 SUB a+~b+cin_e; 0001 INC a+cin_e; 0010 ADD a+b+cin_e; 0011 DEC a+all-ones+cin_e; 0100 XOR; 0101 AND; 0110 OR; 0111 ZERO (y=0); 1000 SHL; 1001 SHR; 1010 SAR; 1011 ROL; 11xx reserved.
REQ-012 cin_e SHALL be the stored carry flag register cf when use_cf=1, else cin; logic, shift and reserved ops SHALL ignore cin_e.
REQ-013 Result and flags SHALL be computed from the accepted inputs and registered on the accept edge; latency 1 cycle (out_valid high the cycle after accept).
REQ-014 Arithmetic: c = carry out of bit WIDTH-1 (SUB uses no-borrow convention, c=1 means a>=b when cin_e=1); v = two's-complement overflow of the WIDTH-bit sum.
REQ-015 Logic ops SHALL drive c=0, v=0; all ops SHALL drive z=(y==0), n=y[WIDTH-1].
REQ-016 Shift amount SHALL be b[$clog2(WIDTH)-1:0]; c = last bit shifted out (0 when amount is 0); v=0; ROL c = y[0].
REQ-017 Reserved ops SHALL produce y=0, z=1, n=0, c=0, v=0, err=1; err SHALL be 0 for all legal ops.
REQ-018 cf SHALL update to c only on accept of an arithmetic op (0000-0011); other ops SHALL leave cf unchanged, so back-to-back multiword chains need no idle cycle.
REQ-019 While out_valid=1 and out_ready=0, y, flags and err SHALL hold stable and no new request SHALL be accepted.
REQ-020 Simultaneous output handshake and accept SHALL replace the result with the new one, out_valid staying 1 (full throughput, one op per cycle).
REQ-021 Output handshake without accept SHALL clear out_valid next cycle; y/flags hold their last value.

Reset
REQ-022 rst_n=0 SHALL immediately force out_valid=0, y=0, z=0, n=0, c=0, v=0, err=0, cf=0, independent of clk.
REQ-023 Reset mid-operation SHALL discard any pending result; the first accept after rst_n release SHALL behave as from power-up.

Configuration
REQ-024 Macro ALU_SHIFT_EN SHALL, when defined, implement ops 1000-1011 per REQ-016.
REQ-025 Without ALU_SHIFT_EN, ops 1xxx SHALL all be treated as reserved per REQ-017 and no shifter logic SHALL be synthesised.

Verification
REQ-026 WIDTH=16, ADD a=0xFFFF b=0x0001 cin=0 -> next cycle out_valid=1, y=0x0000, z=1, c=1, v=0, n=0.
REQ-027 SUB a=0x8000 b=0x0001 cin=1 -> y=0x7FFF, c=1, v=1, n=0, z=0.
REQ-028 ADD 0xFFFF+0x0001 then next cycle ADD a=0 b=0 use_cf=1 cin=0 -> second y=0x0001, c=0; XOR between them leaves chain result unchanged.
REQ-029 Hold out_ready=0 for 3 cycles after accept of AND 0x0F0F&0x00FF -> in_ready=0, y=0x000F stable 3 cycles; out_ready=1 with new request -> next result loaded without bubble.
REQ-030 Assert rst_n=0 between clk edges while out_valid=1 and cf=1 -> out_valid, cf, y drop to 0 before next edge; post-reset ADD use_cf=1 0+0 -> y=0x0000.
REQ-031 op=1000 a=0x8001 b=0x0001: with ALU_SHIFT_EN -> y=0x0002, c=1, err=0; without -> y=0x0000, z=1, err=1.

Source files
------------

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_nbit_seq
// Purpose  : Single-cycle-latency N-bit ALU with valid/ready handshake, stored
//            carry flag for multiword chains. Macro ALU_SHIFT_EN adds shifts.
// Revision : 1.0 - initial release
// ============================================================================
module alu_nbit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             use_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err
);

    localparam logic [3:0] c_OP_SUB  = 4'b0000;
    localparam logic [3:0] c_OP_INC  = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_DEC  = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_OR   = 4'b0110;
    localparam logic [3:0] c_OP_ZERO = 4'b0111;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] c_OP_SHL  = 4'b1000;
    localparam logic [3:0] c_OP_SHR  = 4'b1001;
    localparam logic [3:0] c_OP_SAR  = 4'b1010;
    localparam logic [3:0] c_OP_ROL  = 4'b1011;
    localparam int         c_SHW     = $clog2(WIDTH);
`endif

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             z_q, n_q, c_q, v_q, err_q, cf_q;

    logic [WIDTH-1:0] y_d;
    logic             z_d, n_d, c_d, v_d, err_d;
    logic             w_accept;
    logic             w_arith;
    logic             w_cin_e;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_sum;
`ifdef ALU_SHIFT_EN
    logic [c_SHW-1:0] w_sh;
    assign w_sh = b[c_SHW-1:0];
`endif

    assign in_ready = ~out_valid_q | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_arith  = (op[3:2] == 2'b00);
    assign w_cin_e  = use_cf ? cf_q : cin;

    always_comb begin
        w_op2 = '0;
        case (op)
            c_OP_SUB: w_op2 = ~b;
            c_OP_ADD: w_op2 = b;
            c_OP_DEC: w_op2 = '1;
            default:  w_op2 = '0;
        endcase
        w_sum = {1'b0, a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin_e};

        y_d   = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        err_d = 1'b0;
        case (op)
            c_OP_SUB, c_OP_INC, c_OP_ADD, c_OP_DEC: begin
                y_d = w_sum[WIDTH-1:0];
                c_d = w_sum[WIDTH];
                // Overflow: both addends share a sign that the sum does not.
                v_d = (a[WIDTH-1] == w_op2[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_XOR:  y_d = a ^ b;
            c_OP_AND:  y_d = a & b;
            c_OP_OR:   y_d = a | b;
            c_OP_ZERO: y_d = '0;
`ifdef ALU_SHIFT_EN
            // Extra guard bit catches the last bit shifted out (0 for amount 0).
            c_OP_SHL: {c_d, y_d} = {1'b0, a} << w_sh;
            c_OP_SHR: {y_d, c_d} = {a, 1'b0} >> w_sh;
            c_OP_SAR: {y_d, c_d} = $signed({a, 1'b0}) >>> w_sh;
            c_OP_ROL: begin
                y_d = (a << w_sh) | (a >> (WIDTH - int'(w_sh)));
                c_d = y_d[0];
            end
`endif
            default: err_d = 1'b1;
        endcase
        z_d = (y_d == '0);
        n_d = y_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            cf_q        <= 1'b0;
        end else if (w_accept) begin
            out_valid_q <= 1'b1;
            y_q         <= y_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
            if (w_arith) begin
                cf_q <= c_d;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;
    assign err       = err_q;

endmodule
`default_nettype wire
